dmem_copy_engine: RTL

//  Block-transfer master sitting directly upstream of DataMemory: owns its Address/WriteEn/ReadEn/WriteData

---
 rtl/dmem_copy_engine.sv | 104 ++++++++++
 1 files changed

// File: rtl/dmem_copy_engine.sv
// Block-transfer master for DataMemory: copies Length words from SrcAddr to DstAddr, or fills
// Length words from DstAddr with FillValue, then pulses Done.
module dmem_copy_engine #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Start,
   input  logic                  Mode,
   input  logic [ADDR_WIDTH-1:0] SrcAddr,
   input  logic [ADDR_WIDTH-1:0] DstAddr,
   input  logic [ADDR_WIDTH-1:0] Length,
   input  logic [DATA_WIDTH-1:0] FillValue,
   output logic                  Busy,
   output logic                  Done,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic                  MemWriteEn,
   output logic                  MemReadEn,
   output logic [DATA_WIDTH-1:0] MemWriteData,
   input  logic [DATA_WIDTH-1:0] MemReadData
);

   typedef enum logic [2:0] {StIdle, StRd, StWt, StWr, StDone} stateT;

   localparam logic [ADDR_WIDTH-1:0] AddrOne = 1;

   stateT                 stateQ, stateD;
   logic                  modeQ;
   logic [ADDR_WIDTH-1:0] srcQ, dstQ, remQ;
   logic [DATA_WIDTH-1:0] fillQ, dataQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ <= StIdle;
         modeQ  <= 1'b0;
         srcQ   <= '0;
         dstQ   <= '0;
         remQ   <= '0;
         fillQ  <= '0;
         dataQ  <= '0;
      end else begin
         stateQ <= stateD;
         if (stateQ == StIdle && Start) begin
            modeQ <= Mode;
            srcQ  <= SrcAddr;
            dstQ  <= DstAddr;
            remQ  <= Length;
            fillQ <= FillValue;
         end
         // Read data is valid during WT, one cycle after the RD request edge.
         if (stateQ == StWt) dataQ <= MemReadData;
         if (stateQ == StWr) begin
            srcQ <= srcQ + AddrOne;
            dstQ <= dstQ + AddrOne;
            remQ <= remQ - AddrOne;
         end
      end
   end

   always_comb begin
      stateD       = stateQ;
      Busy         = 1'b0;
      Done         = 1'b0;
      MemAddress   = '0;
      MemWriteEn   = 1'b0;
      MemReadEn    = 1'b0;
      MemWriteData = '0;
      case (stateQ)
         StIdle: begin
            if (Start) begin
               if (Length == '0) stateD = StDone;
               else if (Mode)    stateD = StWr;
               else              stateD = StRd;
            end
         end
         StRd: begin
            Busy       = 1'b1;
            MemReadEn  = 1'b1;
            MemAddress = srcQ;
            stateD     = StWt;
         end
         StWt: begin
            Busy   = 1'b1;
            stateD = StWr;
         end
         StWr: begin
            Busy         = 1'b1;
            MemWriteEn   = 1'b1;
            MemAddress   = dstQ;
            MemWriteData = modeQ ? fillQ : dataQ;
            if (remQ == AddrOne) stateD = StDone;
            else if (modeQ)      stateD = StWr;
            else                 stateD = StRd;
         end
         StDone: begin
            Done   = 1'b1;
            stateD = StIdle;
         end
         default: stateD = StIdle;
      endcase
   end

endmodule
